// File: rtl/ext_mem_model.sv
// rtl/ext_mem_model.sv - cycle-accurate off-chip DRAM model with request FIFO, fixed read latency and refresh stalls
module ext_mem_model #(
    parameter int ADDR_W         = 16,
    parameter int READ_LAT       = 4,
    parameter int Q_DEPTH        = 8,
    parameter int REFRESH_PERIOD = 256,
    parameter int REFRESH_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              request_extmem,
    input  logic              write_extmem,
    input  logic [31:0]       addr_extmem,
    input  logic [31:0]       w_data,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic              valid_extmem,
    output logic [31:0]       data_extmem,
    output logic              busy,
    output logic              overflow
);
    localparam int PTR_W   = $clog2(Q_DEPTH);
    localparam int CNT_MAX = (REFRESH_PERIOD > REFRESH_CYCLES) ? REFRESH_PERIOD : REFRESH_CYCLES;
    localparam int RC_W    = $clog2(CNT_MAX + 1);

    localparam logic [0:0] S_SERVE   = 1'b0;
    localparam logic [0:0] S_REFRESH = 1'b1;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic              q_we   [Q_DEPTH];
    logic [ADDR_W-1:0] q_addr [Q_DEPTH];
    logic [31:0]       q_data [Q_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [PTR_W:0]    count;
    logic [0:0]        state;
    logic [RC_W-1:0]   rcnt;
    logic [READ_LAT-1:0] pipe_v;
    logic [31:0]       pipe_d [READ_LAT];

    logic full, pop, push, rd_pop;
    logic addr_unused;

    assign addr_unused = ^addr_extmem[31:ADDR_W];
    assign full   = (count == (PTR_W+1)'(Q_DEPTH));
    // Preload has priority over the queue; nothing pops during reset or refresh.
    assign pop    = !rst && (state == S_SERVE) && (count != '0) && !load_en;
    assign push   = request_extmem && (!full || pop);
    assign rd_pop = pop && !q_we[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            q_we[wr_ptr]   <= write_extmem;
            q_addr[wr_ptr] <= addr_extmem[ADDR_W-1:0];
            q_data[wr_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            if (request_extmem && !push) overflow <= 1'b1;
        end
    end

    // One counter times both phases: it restarts on refresh entry, so windows recur every REFRESH_PERIOD cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_SERVE;
            rcnt  <= '0;
        end else if (REFRESH_PERIOD != 0) begin
            if (state == S_SERVE) begin
                if (rcnt >= RC_W'(REFRESH_PERIOD - 1)) begin
                    state <= S_REFRESH;
                    rcnt  <= '0;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end else begin
                if (rcnt == RC_W'(REFRESH_CYCLES - 1)) state <= S_SERVE;
                rcnt <= rcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end else if (pop && q_we[rd_ptr]) begin
            mem[q_addr[rd_ptr]] <= q_data[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v <= '0;
            for (int i = 0; i < READ_LAT; i++) pipe_d[i] <= '0;
        end else begin
            for (int i = READ_LAT - 1; i > 0; i--) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
            pipe_v[0] <= rd_pop;
            pipe_d[0] <= rd_pop ? mem[q_addr[rd_ptr]] : 32'h0;
        end
    end

    assign valid_extmem = pipe_v[READ_LAT-1];
    assign data_extmem  = pipe_d[READ_LAT-1];
    assign busy         = (count != '0) || (|pipe_v) || (state == S_REFRESH);

endmodule
